// File: rtl/wb_rr_arbiter_wdt.sv
// Round-robin Wishbone B3 arbiter sharing one slave among num_masters masters,
// with a watchdog that aborts strobes the slave leaves unanswered too long.
module wb_rr_arbiter_wdt #(
  parameter int num_masters    = 2,
  parameter int aw             = 32,
  parameter int dw             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [num_masters*dw-1:0]   wbm_dat_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic                        timeout_o
);

  localparam int GW = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SW = dw / 8;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_grant, w_grant_nxt, w_pick;
  logic [WW-1:0] r_wdt, w_wdt_nxt;
  logic          r_abort_first, w_abort_first_nxt;
  logic          w_cyc_g, w_stb_g, w_any_req, w_resp, w_stalled, w_wdt_limit;

  // Nearest requester after 'last' in circular order; 'last' itself ranks lowest.
  function automatic logic [GW-1:0] rr_pick(input logic [num_masters-1:0] cyc,
                                            input logic [GW-1:0]          last);
    logic [GW-1:0] sel;
    int            best_d;
    int            d;
    sel    = last;
    best_d = num_masters;
    for (int j = 0; j < num_masters; j++) begin
      d = (j + num_masters - int'(last) - 1) % num_masters;
      if (cyc[j] && d < best_d) begin
        best_d = d;
        sel    = GW'(j);
      end
    end
    return sel;
  endfunction

  assign w_cyc_g     = wbm_cyc_i[r_grant];
  assign w_stb_g     = (r_state == BUSY) & w_cyc_g & wbm_stb_i[r_grant];
  assign w_any_req   = |wbm_cyc_i;
  assign w_pick      = rr_pick(wbm_cyc_i, r_grant);
  assign w_resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_stalled   = w_stb_g & ~w_resp;
  assign w_wdt_limit = (TIMEOUT_CYCLES != 0) && (r_wdt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state       <= IDLE;
      r_grant       <= GW'(num_masters - 1);
      r_wdt         <= '0;
      r_abort_first <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_wdt         <= w_wdt_nxt;
      r_abort_first <= w_abort_first_nxt;
    end
  end

  // The watchdog only counts while the granted strobe stays unanswered; an ack
  // on the limit cycle makes w_stalled low, so the response wins over the abort.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_wdt_nxt         = '0;
    w_abort_first_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_grant_nxt = w_pick;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!w_cyc_g) begin
          if (w_any_req) w_grant_nxt = w_pick;
          else           w_state_nxt = IDLE;
        end else if (w_stalled) begin
          if (w_wdt_limit) begin
            w_state_nxt       = ABORT;
            w_abort_first_nxt = 1'b1;
          end else begin
            w_wdt_nxt = r_wdt + WW'(1);
          end
        end
      end
      ABORT: begin
        if (!w_cyc_g) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbs_adr_o = wbm_adr_i[r_grant*aw +: aw];
    wbs_dat_o = wbm_dat_i[r_grant*dw +: dw];
    wbs_sel_o = wbm_sel_i[r_grant*SW +: SW];
    wbs_we_o  = wbm_we_i[r_grant];
    wbs_cti_o = wbm_cti_i[r_grant*3 +: 3];
    wbs_bte_o = wbm_bte_i[r_grant*2 +: 2];
    wbs_cyc_o = (r_state == BUSY) & w_cyc_g;
    wbs_stb_o = w_stb_g;
    wbm_dat_o = {num_masters{wbs_dat_i}};
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    timeout_o = (r_state == ABORT) & r_abort_first;
    if (r_state == BUSY) begin
      wbm_ack_o[r_grant] = wbs_ack_i;
      wbm_err_o[r_grant] = wbs_err_i;
      wbm_rty_o[r_grant] = wbs_rty_i;
    end
    if (timeout_o) wbm_err_o[r_grant] = 1'b1;
  end

endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
// Directed bench for wb_rr_arbiter_wdt: three masters, watchdog limit of 8 cycles.
module tb_wb_rr_arbiter_wdt;
  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM*AW-1:0]   m_adr;
  logic [NM*DW-1:0]   m_dat;
  logic [NM*DW/8-1:0] m_sel;
  logic [NM-1:0]      m_we, m_cyc, m_stb;
  logic [NM*3-1:0]    m_cti;
  logic [NM*2-1:0]    m_bte;
  logic [NM*DW-1:0]   m_dat_o;
  logic [NM-1:0]      m_ack, m_err, m_rty;
  logic [AW-1:0]      s_adr;
  logic [DW-1:0]      s_dat_o, s_dat_i;
  logic [DW/8-1:0]    s_sel;
  logic               s_we, s_cyc, s_stb, s_ack, s_err, s_rty, tmo;
  logic [2:0]         s_cti;
  logic [1:0]         s_bte;

  int n_chk  = 0;
  int n_fail = 0;

  wb_rr_arbiter_wdt #(.num_masters(NM), .aw(AW), .dw(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cti_o(s_cti), .wbs_bte_o(s_bte), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
    .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .timeout_o(tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_adr = {32'h3000, 32'h2000, 32'h1000}; m_dat = '0; m_sel = '0; m_we = '0;
    m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    #2;
    n_chk++; if (s_cyc !== 1'b0) begin $display("FAIL reset_cyc: got %b want 0", s_cyc); n_fail++; end
    n_chk++; if (s_stb !== 1'b0) begin $display("FAIL reset_stb: got %b want 0", s_stb); n_fail++; end
    n_chk++; if ({m_ack, m_err, m_rty} !== 9'b0) begin $display("FAIL reset_resp: got %b want 0", {m_ack, m_err, m_rty}); n_fail++; end
    n_chk++; if (tmo !== 1'b0) begin $display("FAIL reset_timeout: got %b want 0", tmo); n_fail++; end
    step(); step();
    rst = 1'b0;
    step();
    n_chk++; if (s_cyc !== 1'b0) begin $display("FAIL idle_cyc: got %b want 0", s_cyc); n_fail++; end
  endtask

  task automatic test_single_requester();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_sel[7:4] = 4'hA; m_dat[63:32] = 32'h55AA0001;
    #1;
    n_chk++; if (s_cyc !== 1'b0) begin $display("FAIL single_arb_latency: got %b want 0", s_cyc); n_fail++; end
    step();
    #1;
    n_chk++; if ({s_cyc, s_stb} !== 2'b11) begin $display("FAIL single_cyc_stb: got %b want 11", {s_cyc, s_stb}); n_fail++; end
    n_chk++; if (s_adr !== 32'h2000) begin $display("FAIL single_adr: got %h want 2000", s_adr); n_fail++; end
    n_chk++; if (s_sel !== 4'hA || s_dat_o !== 32'h55AA0001) begin $display("FAIL single_sel_dat: got %h %h want a 55aa0001", s_sel, s_dat_o); n_fail++; end
    n_chk++; if (m_ack !== 3'b000) begin $display("FAIL single_noack: got %b want 000", m_ack); n_fail++; end
    step();
    s_ack = 1'b1; s_dat_i = 32'hDEADBEEF;
    #1;
    n_chk++; if (m_ack !== 3'b010) begin $display("FAIL single_ack: got %b want 010", m_ack); n_fail++; end
    n_chk++; if (m_dat_o[63:32] !== 32'hDEADBEEF) begin $display("FAIL single_rdata: got %h want deadbeef", m_dat_o[63:32]); n_fail++; end
    n_chk++; if ({m_err, m_rty} !== 6'b0) begin $display("FAIL single_err_rty: got %b want 0", {m_err, m_rty}); n_fail++; end
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    step(); step();
  endtask

  task automatic test_simultaneous();
    logic [2:0] cti_exp;
    m_cyc = 3'b011; m_stb = 3'b011; m_cti[2:0] = 3'b010; m_cti[5:3] = 3'b000;
    step();
    for (int b = 0; b < 4; b++) begin
      cti_exp = (b == 3) ? 3'b111 : 3'b010;
      m_adr[31:0] = 32'h1000 + 32'(4 * b); m_cti[2:0] = cti_exp; s_ack = 1'b1;
      #1;
      n_chk++; if (s_cyc !== 1'b1 || s_adr !== 32'h1000 + 32'(4 * b)) begin $display("FAIL burst_beat%0d: got cyc=%b adr=%h want cyc=1 adr=%h", b, s_cyc, s_adr, 32'h1000 + 32'(4 * b)); n_fail++; end
      n_chk++; if (s_cti !== cti_exp || m_ack !== 3'b001) begin $display("FAIL burst_cti_ack%0d: got cti=%b ack=%b want cti=%b ack=001", b, s_cti, m_ack, cti_exp); n_fail++; end
      step();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[2:0] = 3'b000; m_adr[31:0] = 32'h1000; s_ack = 1'b0;
    step();
    #1;
    n_chk++; if (s_cyc !== 1'b1 || s_adr !== 32'h2000) begin $display("FAIL handover: got cyc=%b adr=%h want cyc=1 adr=2000", s_cyc, s_adr); n_fail++; end
    s_ack = 1'b1;
    #1;
    n_chk++; if (m_ack !== 3'b010) begin $display("FAIL handover_ack: got %b want 010", m_ack); n_fail++; end
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    step(); step();
  endtask

  task automatic test_fairness();
    int m;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cyc = 3'b111; m_stb = 3'b111;
    step();
    for (int t = 0; t < 9; t++) begin
      m = t % 3;
      s_ack = 1'b1;
      #1;
      n_chk++; if (s_adr !== 32'h1000 * 32'(m + 1) || m_ack !== 3'(1 << m)) begin $display("FAIL fair_txn%0d: got adr=%h ack=%b want adr=%h ack=%b", t, s_adr, m_ack, 32'h1000 * 32'(m + 1), 3'(1 << m)); n_fail++; end
      step();
      s_ack = 1'b0; m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
      #1;
      n_chk++; if (s_cyc !== 1'b0) begin $display("FAIL fair_release%0d: got %b want 0", t, s_cyc); n_fail++; end
      step();
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    end
    m_cyc = '0; m_stb = '0;
    step(); step();
  endtask

  task automatic test_watchdog();
    m_cyc = 3'b001; m_stb = 3'b001;
    step();
    for (int i = 0; i < TO; i++) begin
      if (i == 0) begin m_cyc[1] = 1'b1; m_stb[1] = 1'b1; end
      #1;
      n_chk++; if ({tmo, m_err, s_stb} !== 5'b00001) begin $display("FAIL wdt_stall%0d: got tmo,err,stb=%b want 00001", i, {tmo, m_err, s_stb}); n_fail++; end
      step();
    end
    #1;
    n_chk++; if (tmo !== 1'b1 || m_err !== 3'b001) begin $display("FAIL wdt_fire: got tmo=%b err=%b want tmo=1 err=001", tmo, m_err); n_fail++; end
    n_chk++; if ({s_cyc, s_stb} !== 2'b00) begin $display("FAIL wdt_abort_cyc: got %b want 00", {s_cyc, s_stb}); n_fail++; end
    step();
    #1;
    n_chk++; if ({tmo, m_err, s_cyc} !== 5'b0) begin $display("FAIL wdt_pulse_once: got %b want 0", {tmo, m_err, s_cyc}); n_fail++; end
    step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    n_chk++; if (s_cyc !== 1'b0) begin $display("FAIL wdt_abort_hold: got %b want 0", s_cyc); n_fail++; end
    step();
    step();
    #1;
    n_chk++; if (s_cyc !== 1'b1 || s_adr !== 32'h2000) begin $display("FAIL wdt_next_grant: got cyc=%b adr=%h want cyc=1 adr=2000", s_cyc, s_adr); n_fail++; end
    s_ack = 1'b1;
    #1;
    n_chk++; if (m_ack !== 3'b010) begin $display("FAIL wdt_next_ack: got %b want 010", m_ack); n_fail++; end
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    step(); step();
  endtask

  task automatic test_ack_at_limit();
    m_cyc = 3'b001; m_stb = 3'b001;
    step();
    for (int i = 0; i < TO - 1; i++) begin
      #1;
      n_chk++; if ({tmo, s_stb} !== 2'b01) begin $display("FAIL lim_stall%0d: got tmo,stb=%b want 01", i, {tmo, s_stb}); n_fail++; end
      step();
    end
    s_ack = 1'b1;
    #1;
    n_chk++; if (m_ack !== 3'b001 || tmo !== 1'b0) begin $display("FAIL lim_ack: got ack=%b tmo=%b want ack=001 tmo=0", m_ack, tmo); n_fail++; end
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    #1;
    n_chk++; if (tmo !== 1'b0 || m_err !== 3'b000) begin $display("FAIL lim_no_abort: got tmo=%b err=%b want 0 000", tmo, m_err); n_fail++; end
    step();
    n_chk++; if (tmo !== 1'b0 || s_cyc !== 1'b0) begin $display("FAIL lim_idle: got tmo=%b cyc=%b want 0 0", tmo, s_cyc); n_fail++; end
    step();
  endtask

  task automatic test_reset_mid_burst();
    m_cyc = 3'b010; m_stb = 3'b010; m_cti[5:3] = 3'b010;
    step();
    s_ack = 1'b1;
    #1;
    n_chk++; if (m_ack !== 3'b010) begin $display("FAIL rst_beat1: got %b want 010", m_ack); n_fail++; end
    step();
    #1;
    n_chk++; if (m_ack !== 3'b010 || s_cyc !== 1'b1) begin $display("FAIL rst_beat2: got ack=%b cyc=%b want 010 1", m_ack, s_cyc); n_fail++; end
    rst = 1'b1;
    #1;
    n_chk++; if ({s_cyc, s_stb} !== 2'b00) begin $display("FAIL rst_async_cyc: got %b want 00", {s_cyc, s_stb}); n_fail++; end
    n_chk++; if ({m_ack, m_err, m_rty, tmo} !== 10'b0) begin $display("FAIL rst_async_resp: got %b want 0", {m_ack, m_err, m_rty, tmo}); n_fail++; end
    s_ack = 1'b0; m_cti = '0; m_cyc = 3'b111; m_stb = 3'b111;
    step(); step();
    rst = 1'b0;
    step();
    #1;
    n_chk++; if (s_cyc !== 1'b1 || s_adr !== 32'h1000) begin $display("FAIL rst_first_grant: got cyc=%b adr=%h want 1 1000", s_cyc, s_adr); n_fail++; end
    s_ack = 1'b1;
    #1;
    n_chk++; if (m_ack !== 3'b001) begin $display("FAIL rst_first_ack: got %b want 001", m_ack); n_fail++; end
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single_requester();
    test_simultaneous();
    test_fairness();
    test_watchdog();
    test_ack_at_limit();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
